// File: rtl/binary_search_guesser_pkg.sv
// search_pkg: shared state encoding and width helper for the binary-search guesser.
// Contents: search_state_t (IDLE/PROBE/DONE/ERROR) and STEP_W(w), the width of a probe counter for a w-bit search.
package search_pkg;
    typedef enum logic [1:0] {IDLE, PROBE, DONE, ERROR} search_state_t;
    // The largest count is w+1 probes, so the counter must hold values up to w+1.
    function automatic int STEP_W(input int w);
        return $clog2(w + 2);
    endfunction
endpackage

// File: rtl/binary_search_guesser_if.sv
// binary_search_guesser_if: compare bus between the guesser and its comparator.
// Signals:
//   guess, guess_valid  - probe value and its qualifier, driven by the master.
//   resp_valid          - verdict qualifier, driven by the slave.
//   is_lt, is_gt, is_eq - verdict flags, driven by the slave.
// is_lt means S < G, where S is the hidden value and G is the guess.
interface binary_search_guesser_if #(parameter int WIDTH = 3);
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             resp_valid;
    logic             is_lt;
    logic             is_gt;
    logic             is_eq;
    modport master(output guess, guess_valid, input resp_valid, is_lt, is_gt, is_eq);
    modport slave(input guess, guess_valid, output resp_valid, is_lt, is_gt, is_eq);
endinterface

// File: rtl/binary_search_guesser.sv
// binary_search_guesser: binary search for a hidden value, driven by comparator verdicts.
// Ports:
//   clk     - rising-edge clock.
//   reset_n - asynchronous active-low reset.
//   start   - starts a search; honoured only in IDLE, DONE or ERROR.
//   cmp     - compare bus (master side): guess/guess_valid out, resp_valid/is_lt/is_gt/is_eq in.
//   done    - level high when the search succeeded; found is then valid.
//   error   - level high when the verdict sequence was inconsistent.
//   found   - recovered value; holds its value until a later search succeeds.
//   steps   - number of accepted verdicts in the current or last search.
module binary_search_guesser
    import search_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    binary_search_guesser_if.master   cmp,
    output logic                      done,
    output logic                      error,
    output logic [WIDTH-1:0]          found,
    output logic [STEP_W(WIDTH)-1:0]  steps
);
    search_state_t              state_q;
    logic [WIDTH-1:0]           lo_q, hi_q, found_q, mid_d;
    logic [STEP_W(WIDTH)-1:0]   steps_q;
    logic                       gv_q, done_q, err_q;
    logic [2:0]                 flags;
    // Written as lo + half-span so the sum never overflows while lo <= hi.
    always_comb mid_d = lo_q + ((hi_q - lo_q) >> 1);
    assign flags           = {cmp.is_lt, cmp.is_gt, cmp.is_eq};
    assign cmp.guess       = mid_d;
    assign cmp.guess_valid = gv_q;
    assign done            = done_q;
    assign error           = err_q;
    assign found           = found_q;
    assign steps           = steps_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '1;
            found_q <= '0;
            steps_q <= '0;
            gv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (state_q == PROBE) begin
            if (cmp.resp_valid) begin
                steps_q <= steps_q + 1'b1;
                // A verdict that would push the range past its own edge
                // contradicts earlier verdicts, so it is an error.
                if (flags == 3'b001) begin
                    found_q <= mid_d;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    gv_q    <= 1'b0;
                end else if (flags == 3'b100 && mid_d != lo_q) begin
                    hi_q <= mid_d - 1'b1;
                end else if (flags == 3'b010 && mid_d != hi_q) begin
                    lo_q <= mid_d + 1'b1;
                end else begin
                    state_q <= ERROR;
                    err_q   <= 1'b1;
                    gv_q    <= 1'b0;
                end
            end
        end else if (start) begin
            state_q <= PROBE;
            lo_q    <= '0;
            hi_q    <= '1;
            steps_q <= '0;
            gv_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_binary_search_guesser.sv
// tb_binary_search_guesser: scoreboard bench for binary_search_guesser with WIDTH=3.
module tb_binary_search_guesser;
    typedef struct {
        logic       d;
        logic       e;
        logic [2:0] f;
        logic [2:0] s;
    } res_t;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       done, error;
    logic [2:0] found, steps;
    logic [2:0] s_val = 3'd0;
    int         mode = 0;
    logic       rv = 1'b1;
    logic       prev_fin = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_g[$];
    res_t       exp_r[$];
    binary_search_guesser_if #(.WIDTH(3)) bus();
    binary_search_guesser #(.WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmp(bus),
        .done(done), .error(error), .found(found), .steps(steps)
    );
    always #5 clk = ~clk;
    // Responder: mode 0 is a correct comparator with A=S and B=guess,
    // mode 1 always answers is_lt, mode 2 answers is_lt and is_gt together.
    assign bus.resp_valid = rv;
    assign bus.is_lt = (mode != 0) ? 1'b1 : (s_val < bus.guess);
    assign bus.is_gt = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (s_val > bus.guess);
    assign bus.is_eq = (mode == 0) && (s_val == bus.guess);
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.guess_valid && bus.resp_valid) begin
            if (exp_g.size() == 0) chk("unexpected_probe", int'(bus.guess), -1);
            else chk("guess", int'(bus.guess), int'(exp_g.pop_front()));
        end
        if ((done || error) && !prev_fin) begin
            if (exp_r.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                res_t r;
                r = exp_r.pop_front();
                chk("done", int'(done), int'(r.d));
                chk("error", int'(error), int'(r.e));
                chk("found", int'(found), int'(r.f));
                chk("steps", int'(steps), int'(r.s));
            end
        end
        prev_fin <= done || error;
    end
    task automatic start_search(input logic [2:0] s, input int m);
        @(posedge clk);
        #1 s_val = s;
        mode = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    task automatic wait_fin;
        int n = 0;
        while (!(done || error) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) chk("timeout", 0, 1);
        @(negedge clk);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_steps", int'(steps), 0);
        chk("rst_gv", int'(bus.guess_valid), 0);
        chk("rst_guess", int'(bus.guess), 3);
        exp_g.push_back(3'd3); exp_g.push_back(3'd5);
        exp_r.push_back('{1'b1, 1'b0, 3'd5, 3'd2});
        start_search(3'd5, 0); wait_fin();
        exp_g.push_back(3'd3); exp_g.push_back(3'd1); exp_g.push_back(3'd0);
        exp_r.push_back('{1'b1, 1'b0, 3'd0, 3'd3});
        start_search(3'd0, 0); wait_fin();
        exp_g.push_back(3'd3); exp_g.push_back(3'd5); exp_g.push_back(3'd6); exp_g.push_back(3'd7);
        exp_r.push_back('{1'b1, 1'b0, 3'd7, 3'd4});
        start_search(3'd7, 0); wait_fin();
        exp_g.push_back(3'd3); exp_g.push_back(3'd1); exp_g.push_back(3'd0);
        exp_r.push_back('{1'b0, 1'b1, 3'd7, 3'd3});
        start_search(3'd4, 1); wait_fin();
        exp_g.push_back(3'd3);
        exp_r.push_back('{1'b0, 1'b1, 3'd7, 3'd1});
        start_search(3'd4, 2); wait_fin();
        exp_g.push_back(3'd3); exp_g.push_back(3'd1); exp_g.push_back(3'd2);
        exp_r.push_back('{1'b1, 1'b0, 3'd2, 3'd3});
        start_search(3'd2, 0); wait_fin();
        exp_g.push_back(3'd3); exp_g.push_back(3'd5);
        exp_r.push_back('{1'b1, 1'b0, 3'd5, 3'd2});
        @(posedge clk);
        #1 rv = 1'b0;
        start_search(3'd5, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_guess", int'(bus.guess), 3);
            chk("hold_gv", int'(bus.guess_valid), 1);
            chk("hold_steps", int'(steps), 0);
        end
        @(posedge clk);
        #1 rv = 1'b1;
        wait_fin();
        exp_g.push_back(3'd3);
        start_search(3'd6, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_done", int'(done), 0);
        chk("arst_error", int'(error), 0);
        chk("arst_found", int'(found), 0);
        chk("arst_steps", int'(steps), 0);
        chk("arst_gv", int'(bus.guess_valid), 0);
        chk("arst_guess", int'(bus.guess), 3);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_g.push_back(3'd3); exp_g.push_back(3'd5); exp_g.push_back(3'd6);
        exp_r.push_back('{1'b1, 1'b0, 3'd6, 3'd3});
        start_search(3'd6, 0); wait_fin();
        chk("leftover_expectations", exp_g.size() + exp_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
